// File: rtl/fifo_pkg.sv
// Shared constants for the single-clock FIFO.
package fifo_pkg;

    localparam int unsigned DATA_WIDTH = 8;
    localparam int unsigned ADDR_WIDTH = 3;
    localparam int unsigned DEPTH      = 1 << ADDR_WIDTH;

endpackage

// File: rtl/async_fifo_if.sv
// Producer/consumer bundle of the FIFO: push/pop strobes, write data, status and read data.
interface async_fifo_if
    import fifo_pkg::*;
#(
    parameter int unsigned DW = DATA_WIDTH
);

    logic [DW-1:0] i_wdata_in;
    logic          i_wr;
    logic          i_rd;
    logic          o_wfull;
    logic          o_rempty;
    logic [DW-1:0] o_rdata_out;

    // Side that drives the strobes (producer/consumer).
    modport master (
        output i_wdata_in,
        output i_wr,
        output i_rd,
        input  o_wfull,
        input  o_rempty,
        input  o_rdata_out
    );

    // The FIFO itself.
    modport slave (
        input  i_wdata_in,
        input  i_wr,
        input  i_rd,
        output o_wfull,
        output o_rempty,
        output o_rdata_out
    );

endinterface

// File: rtl/fifo_mem.sv
// Register-array storage with a synchronous write port and a registered read port.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = fifo_pkg::DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = fifo_pkg::ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int unsigned Depth = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [Depth];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Storage write; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Registered read data: cleared by reset, otherwise holds unless a pop is accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/async_fifo.sv
// Single-clock 8x8 FIFO; name kept for drop-in compatibility (no clock crossing inside).
module async_fifo
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = fifo_pkg::DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = fifo_pkg::ADDR_WIDTH
) (
    input  logic         i_clk,
    input  logic         i_reset,
    async_fifo_if.slave  bus
);

    // One extra pointer bit distinguishes full from empty when the address bits match.
    logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
    logic                full, empty;
    logic                wr_en, rd_en;

    // Flags decoded from the registered pointers; strobes qualified against pre-edge flags.
    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]) &&
                   (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]);
        wr_en    = bus.i_wr && !full && !i_reset;
        rd_en    = bus.i_rd && !empty && !i_reset;
        wr_ptr_d = wr_ptr_q + {{ADDR_WIDTH{1'b0}}, wr_en};
        rd_ptr_d = rd_ptr_q + {{ADDR_WIDTH{1'b0}}, rd_en};
    end

    // Pointer registers; reset wins over any push/pop in the same cycle.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    assign bus.o_wfull  = full;
    assign bus.o_rempty = empty;

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk   (i_clk),
        .reset (i_reset),
        .we    (wr_en),
        .waddr (wr_ptr_q[ADDR_WIDTH-1:0]),
        .wdata (bus.i_wdata_in),
        .re    (rd_en),
        .raddr (rd_ptr_q[ADDR_WIDTH-1:0]),
        .rdata (bus.o_rdata_out)
    );

endmodule

// File: tb/tb_async_fifo.sv
// Bench for async_fifo: directed phases plus random traffic against a queue-based model.
module tb_async_fifo;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    async_fifo_if ifc ();

    async_fifo dut (
        .i_clk   (clk),
        .i_reset (reset),
        .bus     (ifc)
    );

    // Reference model: contents, expected held read data, and scoreboard of popped words.
    logic [7:0] model_q [$];
    logic [7:0] sb_q [$];
    logic [7:0] exp_rdata;

    int n_checks = 0;
    int n_fail   = 0;
    logic pre_fire = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle's inputs and advance the model to the state after the coming edge.
    task automatic apply(input bit rst, input bit wr, input bit rd, input logic [7:0] d);
        bit wr_ok, rd_ok;
        logic [7:0] v;
        reset          = rst;
        ifc.i_wr       = wr;
        ifc.i_rd       = rd;
        ifc.i_wdata_in = d;
        if (rst) begin
            model_q.delete();
            exp_rdata = 8'h00;
        end else begin
            rd_ok = rd && (model_q.size() > 0);
            wr_ok = wr && (model_q.size() < 8);
            if (rd_ok) begin
                v = model_q.pop_front();
                sb_q.push_back(v);
                exp_rdata = v;
            end
            if (wr_ok) model_q.push_back(d);
        end
    endtask

    task automatic step(input bit rst, input bit wr, input bit rd, input logic [7:0] d);
        apply(rst, wr, rd, d);
        @(posedge clk);
        #2;
    endtask

    // A pop is presented whenever a read strobe meets a non-empty FIFO outside reset.
    always @(negedge clk) begin
        pre_fire <= ifc.i_rd && !ifc.o_rempty && !reset;
    end

    // Monitor: status every cycle, popped data against the scoreboard.
    always @(posedge clk) begin
        #1;
        check("rempty", {31'd0, ifc.o_rempty}, {31'd0, model_q.size() == 0});
        check("wfull", {31'd0, ifc.o_wfull}, {31'd0, model_q.size() == 8});
        check("rdata_hold", {24'd0, ifc.o_rdata_out}, {24'd0, exp_rdata});
        if (pre_fire) begin
            if (sb_q.size() == 0) begin
                check("unexpected_pop", 32'd1, 32'd0);
            end else begin
                check("pop_data", {24'd0, ifc.o_rdata_out}, {24'd0, sb_q.pop_front()});
            end
        end
    end

    initial begin
        // Reset with both strobes high: nothing must be stored.
        step(1'b1, 1'b1, 1'b1, 8'h33);
        step(1'b0, 1'b0, 1'b0, 8'h00);

        // Fill 0..7, then a write while full.
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 8'(i));
        step(1'b0, 1'b1, 1'b0, 8'hFF);

        // Drain, then a read while empty.
        for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 1'b1, 8'h00);

        // Wrap-around pass.
        for (int i = 8; i < 16; i++) step(1'b0, 1'b1, 1'b0, 8'(i));
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1, 8'h00);

        // Simultaneous traffic with 3 words stored.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 8'(8'h20 + i));
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, 8'(8'h30 + i));

        // Reset with 5 stored, then A5 through.
        for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 1'b0, 8'(8'h40 + i));
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b0, 8'hA5);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00);

        // Simultaneous push/pop on a full FIFO.
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 8'(8'h50 + i));
        step(1'b0, 1'b1, 1'b1, 8'h77);
        step(1'b0, 1'b1, 1'b1, 8'h78);

        // Random traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 63) == 0), 1'($urandom), 1'($urandom), 8'($urandom));
        end

        // Drain whatever is left.
        for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00);

        check("scoreboard_empty", sb_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/async_fifo.md
Name: async_fifo

Overview:
- Single-clock, 8-bit-wide, 8-entry first-in-first-out buffer between a producer and a consumer in the same clock domain.
- Provides push/pop strobes, full/empty status and a registered read-data output.
- Keeps the legacy block name for drop-in compatibility. All logic is on one clock, so no clock-domain-crossing logic is present.

Parameters:
- DATA_WIDTH, 8, width of each stored word and of i_wdata_in/o_rdata_out
- ADDR_WIDTH, 3, log2 of depth; depth = 2**ADDR_WIDTH = 8 entries

Ports:
- i_clk  input  1  sole clock; all state updates on rising edge
- i_reset  input  1  synchronous, active-high reset
- i_wdata_in  input  DATA_WIDTH  write data, sampled on an accepted write
- i_wr  input  1  write request (push)
- i_rd  input  1  read request (pop)
- o_wfull  output  1  FIFO holds 8 words
- o_rempty  output  1  FIFO holds 0 words
- o_rdata_out  output  DATA_WIDTH  registered read data

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset (i_reset=1 at a rising edge):
  - write and read pointers go to 0;
  - o_rempty=1, o_wfull=0, o_rdata_out=0;
  - memory contents are not cleared;
  - reset takes priority over i_wr/i_rd in the same cycle;
  - mid-operation reset discards all stored words.
- Pointers: wr_ptr and rd_ptr are ADDR_WIDTH+1 bits (4 bits). The low ADDR_WIDTH bits address memory. The MSB is a wrap bit. Pointers increment modulo 2**(ADDR_WIDTH+1).
- Flags: combinational decode of the registered pointers, so each updates in the same cycle the pointers change (visible right after the edge).
  - empty = (wr_ptr == rd_ptr).
  - full = low bits equal and MSBs differ.
- Write is accepted when i_wr=1 and o_wfull=0 at the edge:
  - mem[wr_ptr[2:0]] <= i_wdata_in;
  - wr_ptr increments.
- A write while full is ignored: no memory or pointer change.
- Read is accepted when i_rd=1 and o_rempty=0 at the edge:
  - o_rdata_out <= mem[rd_ptr[2:0]] (one-cycle latency, data valid after that edge);
  - rd_ptr increments.
- A read while empty is ignored, and o_rdata_out holds its previous value. o_rdata_out also holds whenever no read is accepted.
- Simultaneous read and write: each is qualified against the flags present before the edge.
  - When neither empty nor full, both occur and the occupancy is unchanged.
  - When full, only the read occurs.
  - When empty, only the write occurs; the newly written word is not bypassed to the output.
- Data order is strict FIFO across pointer wrap-around.

Decomposition:
- Shared package fifo_pkg holds DATA_WIDTH and ADDR_WIDTH defaults and the derived DEPTH constant.
- One natural sub-module, fifo_mem: an 8x8 register array with synchronous write port and synchronous registered read port, instantiated by async_fifo.
- Pointer and flag logic stays in the top module.

Test Plan:
- Reset: assert i_reset for one edge with i_wr=i_rd=1 -> o_rempty=1, o_wfull=0, o_rdata_out=0; no word stored.
- Fill: i_wr=1 for 8 edges with data 0..7 -> o_rempty=0 after the first edge, o_wfull=1 after the eighth; a ninth write of 8'hFF is ignored and o_wfull stays 1.
- Drain: i_rd=1 for 8 edges -> o_rdata_out shows 0,1,...,7 one per edge; o_wfull drops after the first read, o_rempty=1 after the eighth; an extra read keeps o_rdata_out=7.
- Wrap-around: after the drain, write 8..15, then read 8 words -> outputs 8..15 in order, pointer MSB toggled, full/empty correct.
- Simultaneous traffic: with 3 words stored, i_wr=i_rd=1 for 4 cycles -> occupancy stays 3, flags unchanged, reads return the oldest words in order.
- Reset mid-operation: with 5 words stored, assert i_reset -> o_rempty=1, o_wfull=0, o_rdata_out=0; a subsequent write of 8'hA5 followed by a read returns 8'hA5.
